// File: rtl/ecc_apb_pkg.sv
// Shared register map, mode/status codes and state encodings for the ECC APB initiator.
package ecc_apb_pkg;

  localparam logic [7:0] CTRL           = 8'h00;
  localparam logic [7:0] DATA_IN        = 8'h04;
  localparam logic [7:0] CODEWORD_WIDTH = 8'h08;
  localparam logic [7:0] NOISE          = 8'h0C;

  localparam logic [1:0] ENCODER_ONLY = 2'b00;
  localparam logic [1:0] DECODER_ONLY = 2'b01;
  localparam logic [1:0] FULL_CHANNEL = 2'b10;

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_TIMEOUT = 2'b01;
  localparam logic [1:0] ST_ILLEGAL = 2'b10;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_SETUP     = 3'd1;
  localparam logic [2:0] S_ACCESS    = 3'd2;
  localparam logic [2:0] S_WAIT_DONE = 3'd3;
  localparam logic [2:0] S_RESULT    = 3'd4;

  localparam logic [1:0] X_IDLE   = 2'd0;
  localparam logic [1:0] X_SETUP  = 2'd1;
  localparam logic [1:0] X_ACCESS = 2'd2;

  // Programming order: NOISE, CODEWORD_WIDTH, DATA_IN, CTRL (CTRL last starts the operation).
  function automatic logic [7:0] reg_addr(input logic [1:0] idx);
    case (idx)
      2'd0:    reg_addr = NOISE;
      2'd1:    reg_addr = CODEWORD_WIDTH;
      2'd2:    reg_addr = DATA_IN;
      default: reg_addr = CTRL;
    endcase
  endfunction

endpackage

// File: rtl/ecc_apb_master_if.sv
// APB write port plus the ECC slave completion/result signals.
interface ecc_apb_master_if #(
  parameter int unsigned AMBA_WORD       = 16,
  parameter int unsigned AMBA_ADDR_WIDTH = 20,
  parameter int unsigned DATA_WIDTH      = 16
);
  logic [AMBA_ADDR_WIDTH-1:0] PADDR;
  logic [AMBA_WORD-1:0]       PWDATA;
  logic                       PSEL;
  logic                       PENABLE;
  logic                       PWRITE;
  logic                       operation_done;
  logic [DATA_WIDTH-1:0]      data_out;
  logic [1:0]                 num_of_errors;

  modport master (
    output PADDR, PWDATA, PSEL, PENABLE, PWRITE,
    input  operation_done, data_out, num_of_errors
  );

  modport slave (
    input  PADDR, PWDATA, PSEL, PENABLE, PWRITE,
    output operation_done, data_out, num_of_errors
  );
endinterface

// File: rtl/ecc_apb_xfer.sv
// Single APB write transfer engine: start -> SETUP -> ACCESS (done); a start in ACCESS chains a new SETUP.
module ecc_apb_xfer
  import ecc_apb_pkg::*;
#(
  parameter int unsigned AMBA_WORD       = 16,
  parameter int unsigned AMBA_ADDR_WIDTH = 20
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [AMBA_ADDR_WIDTH-1:0] addr,
  input  logic [AMBA_WORD-1:0]       wdata,
  output logic [AMBA_ADDR_WIDTH-1:0] paddr,
  output logic [AMBA_WORD-1:0]       pwdata,
  output logic                       psel,
  output logic                       penable,
  output logic                       pwrite,
  output logic                       done
);
  logic [1:0] phase;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase  <= X_IDLE;
      paddr  <= '0;
      pwdata <= '0;
    end else if (start && phase != X_SETUP) begin
      phase  <= X_SETUP;
      paddr  <= addr;
      pwdata <= wdata;
    end else if (phase == X_SETUP) begin
      phase <= X_ACCESS;
    end else begin
      phase <= X_IDLE;
    end
  end

  assign psel    = (phase != X_IDLE);
  assign penable = (phase == X_ACCESS);
  assign pwrite  = psel;
  assign done    = penable;
endmodule

// File: rtl/ecc_apb_master.sv
// Job-level APB initiator: programs NOISE/CODEWORD_WIDTH/DATA_IN/CTRL, waits for completion, returns a result strobe.
module ecc_apb_master
  import ecc_apb_pkg::*;
#(
  parameter int unsigned AMBA_WORD       = 16,
  parameter int unsigned AMBA_ADDR_WIDTH = 20,
  parameter int unsigned DATA_WIDTH      = 16,
  parameter int unsigned TIMEOUT_CYCLES  = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  job_valid,
  output logic                  job_ready,
  input  logic [1:0]            job_mode,
  input  logic [1:0]            job_width,
  input  logic [DATA_WIDTH-1:0] job_data,
  input  logic [DATA_WIDTH-1:0] job_noise,
  ecc_apb_master_if.master      apb,
  output logic                  res_valid,
  output logic [DATA_WIDTH-1:0] res_data,
  output logic [1:0]            res_errors,
  output logic [1:0]            res_status,
  output logic                  busy
);
  localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [2:0]            state;
  logic [1:0]            idx;
  logic [1:0]            next_idx;
  logic [1:0]            sh_width;
  logic [1:0]            sh_mode;
  logic [DATA_WIDTH-1:0] sh_data;
  logic [TW-1:0]         timer;
  logic                  accept;
  logic                  legal;
  logic                  start;
  logic                  xfer_done;
  logic [AMBA_WORD-1:0]  wdata;

  assign job_ready = (state == S_IDLE);
  assign busy      = ~job_ready;
  assign res_valid = (state == S_RESULT);
  assign accept    = job_valid && job_ready;
  assign legal     = job_mode inside {ENCODER_ONLY, DECODER_ONLY, FULL_CHANNEL};

  // The first transfer is launched from IDLE, so NOISE comes straight from the job port.
  always_comb begin
    next_idx = (state == S_ACCESS) ? idx + 2'd1 : 2'd0;
    start    = (accept && legal) || (state == S_ACCESS && idx != 2'd3);
    case (next_idx)
      2'd0:    wdata = AMBA_WORD'(job_noise);
      2'd1:    wdata = AMBA_WORD'(sh_width);
      2'd2:    wdata = AMBA_WORD'(sh_data);
      default: wdata = AMBA_WORD'(sh_mode);
    endcase
  end

  ecc_apb_xfer #(
    .AMBA_WORD       (AMBA_WORD),
    .AMBA_ADDR_WIDTH (AMBA_ADDR_WIDTH)
  ) u_xfer (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .addr    (AMBA_ADDR_WIDTH'(reg_addr(next_idx))),
    .wdata   (wdata),
    .paddr   (apb.PADDR),
    .pwdata  (apb.PWDATA),
    .psel    (apb.PSEL),
    .penable (apb.PENABLE),
    .pwrite  (apb.PWRITE),
    .done    (xfer_done)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      idx        <= '0;
      sh_width   <= '0;
      sh_mode    <= '0;
      sh_data    <= '0;
      timer      <= '0;
      res_data   <= '0;
      res_errors <= '0;
      res_status <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            sh_width <= job_width;
            sh_mode  <= job_mode;
            sh_data  <= job_data;
            idx      <= '0;
            if (legal) begin
              state <= S_SETUP;
            end else begin
              res_status <= ST_ILLEGAL;
              res_data   <= '0;
              res_errors <= '0;
              state      <= S_RESULT;
            end
          end
        end
        S_SETUP: state <= S_ACCESS;
        S_ACCESS: begin
          if (xfer_done) begin
            if (idx == 2'd3) begin
              timer <= '0;
              state <= S_WAIT_DONE;
            end else begin
              idx   <= idx + 2'd1;
              state <= S_SETUP;
            end
          end
        end
        S_WAIT_DONE: begin
          // A completion on the last timeout cycle still counts as success.
          if (apb.operation_done) begin
            res_data   <= apb.data_out;
            res_errors <= apb.num_of_errors;
            res_status <= ST_OK;
            state      <= S_RESULT;
          end else if (timer == TW'(TIMEOUT_CYCLES - 1)) begin
            res_data   <= '0;
            res_errors <= '0;
            res_status <= ST_TIMEOUT;
            state      <= S_RESULT;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        S_RESULT: state <= S_IDLE;
        default:  state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ecc_apb_master.sv
// Scoreboard bench for ecc_apb_master: expected APB writes/results queued at stimulus time, checked as they appear.
module tb_ecc_apb_master;
  typedef struct {
    int unsigned cyc;
    logic [19:0] addr;
    logic [15:0] data;
  } wr_t;

  typedef struct {
    int unsigned cyc;
    logic [1:0]  status;
    logic [1:0]  errors;
    logic [15:0] data;
  } res_t;

  logic        clk;
  logic        rst;
  logic        job_valid;
  logic        job_ready;
  logic [1:0]  job_mode;
  logic [1:0]  job_width;
  logic [15:0] job_data;
  logic [15:0] job_noise;
  logic        res_valid;
  logic [15:0] res_data;
  logic [1:0]  res_errors;
  logic [1:0]  res_status;
  logic        busy;

  int unsigned cyc;
  int          checks;
  int          failures;
  int unsigned psel_cnt;
  wr_t         exp_wr[$];
  res_t        exp_res[$];
  int unsigned acc_q[$];

  ecc_apb_master_if #(.AMBA_WORD(16), .AMBA_ADDR_WIDTH(20), .DATA_WIDTH(16)) apb ();

  ecc_apb_master #(
    .AMBA_WORD       (16),
    .AMBA_ADDR_WIDTH (20),
    .DATA_WIDTH      (16),
    .TIMEOUT_CYCLES  (64)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .job_valid  (job_valid),
    .job_ready  (job_ready),
    .job_mode   (job_mode),
    .job_width  (job_width),
    .job_data   (job_data),
    .job_noise  (job_noise),
    .apb        (apb),
    .res_valid  (res_valid),
    .res_data   (res_data),
    .res_errors (res_errors),
    .res_status (res_status),
    .busy       (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1);
  end

  // Monitor/scoreboard: sampled on the falling edge, away from the active edge.
  initial begin
    logic        in_setup;
    logic [19:0] s_addr;
    logic [15:0] s_data;
    wr_t         we;
    res_t        re;
    in_setup = 1'b0;
    s_addr   = '0;
    s_data   = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        in_setup = 1'b0;
      end else begin
        if (job_valid && job_ready) acc_q.push_back(cyc);
        if (apb.PSEL) psel_cnt++;
        if (apb.PSEL && !apb.PENABLE) begin
          checks++;
          if (in_setup || apb.PWRITE !== 1'b1) begin
            failures++;
            $display("FAIL apb_setup cyc=%0d repeated_setup=%0b pwrite=%b required pwrite=1 after non-setup", cyc, in_setup, apb.PWRITE);
          end
          in_setup = 1'b1;
          s_addr   = apb.PADDR;
          s_data   = apb.PWDATA;
        end else if (apb.PSEL && apb.PENABLE) begin
          checks++;
          if (!in_setup || apb.PADDR !== s_addr || apb.PWDATA !== s_data || apb.PWRITE !== 1'b1) begin
            failures++;
            $display("FAIL apb_access cyc=%0d had_setup=%0b addr=%h/%h data=%h/%h pwrite=%b required stable and pwrite=1",
                     cyc, in_setup, apb.PADDR, s_addr, apb.PWDATA, s_data, apb.PWRITE);
          end
          in_setup = 1'b0;
          checks++;
          if (exp_wr.size() == 0) begin
            failures++;
            $display("FAIL apb_write unexpected addr=%h data=%h cyc=%0d required none", apb.PADDR, apb.PWDATA, cyc);
          end else begin
            we = exp_wr.pop_front();
            if (apb.PADDR !== we.addr || apb.PWDATA !== we.data || cyc !== we.cyc) begin
              failures++;
              $display("FAIL apb_write got addr=%h data=%h cyc=%0d required addr=%h data=%h cyc=%0d",
                       apb.PADDR, apb.PWDATA, cyc, we.addr, we.data, we.cyc);
            end
          end
        end else begin
          if (apb.PENABLE !== 1'b0 || in_setup) begin
            checks++;
            failures++;
            $display("FAIL apb_idle cyc=%0d penable=%b pending_setup=%0b required penable=0 and access after setup",
                     cyc, apb.PENABLE, in_setup);
          end
          in_setup = 1'b0;
        end
        if (res_valid) begin
          checks++;
          if (exp_res.size() == 0) begin
            failures++;
            $display("FAIL result unexpected cyc=%0d status=%b data=%h required none", cyc, res_status, res_data);
          end else begin
            re = exp_res.pop_front();
            if (cyc !== re.cyc || res_status !== re.status || res_errors !== re.errors || res_data !== re.data) begin
              failures++;
              $display("FAIL result got cyc=%0d status=%b errors=%0d data=%h required cyc=%0d status=%b errors=%0d data=%h",
                       cyc, res_status, res_errors, res_data, re.cyc, re.status, re.errors, re.data);
            end
          end
        end
      end
    end
  end

  task automatic wait_until(input int unsigned c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_writes(input int unsigned t, input logic [1:0] mode, input logic [1:0] width,
                             input logic [15:0] data, input logic [15:0] noise);
    logic [19:0] a[4];
    logic [15:0] d[4];
    a[0] = 20'hC; d[0] = noise;
    a[1] = 20'h8; d[1] = {14'd0, width};
    a[2] = 20'h4; d[2] = data;
    a[3] = 20'h0; d[3] = {14'd0, mode};
    for (int k = 0; k < 4; k++)
      exp_wr.push_back('{cyc: t + 2 + 2 * k, addr: a[k], data: d[k]});
  endtask

  // One-cycle job request; fields are scrambled afterwards to prove they were latched.
  task automatic start_job(input logic [1:0] mode, input logic [1:0] width, input logic [15:0] data,
                           input logic [15:0] noise, output int unsigned t);
    @(posedge clk);
    #1;
    job_mode  = mode;
    job_width = width;
    job_data  = data;
    job_noise = noise;
    job_valid = 1'b1;
    t = cyc;
    if (mode != 2'b11) push_writes(t, mode, width, data, noise);
    @(posedge clk);
    #1;
    job_valid = 1'b0;
    job_mode  = 2'($urandom);
    job_width = 2'($urandom);
    job_data  = 16'($urandom);
    job_noise = 16'($urandom);
  endtask

  task automatic test_reset;
    #12;
    checks++;
    if (apb.PSEL !== 1'b0 || apb.PENABLE !== 1'b0 || apb.PWRITE !== 1'b0) begin
      failures++;
      $display("FAIL reset_apb_ctrl psel=%b penable=%b pwrite=%b required 0 0 0", apb.PSEL, apb.PENABLE, apb.PWRITE);
    end
    checks++;
    if (apb.PADDR !== 20'h0 || apb.PWDATA !== 16'h0) begin
      failures++;
      $display("FAIL reset_apb_bus paddr=%h pwdata=%h required 0 0", apb.PADDR, apb.PWDATA);
    end
    checks++;
    if (res_valid !== 1'b0 || res_data !== 16'h0 || res_errors !== 2'd0 || res_status !== 2'd0) begin
      failures++;
      $display("FAIL reset_result valid=%b data=%h errors=%0d status=%b required 0 0 0 0", res_valid, res_data, res_errors, res_status);
    end
    checks++;
    if (job_ready !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_ready job_ready=%b busy=%b required 1 0", job_ready, busy);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic test_full_job;
    int unsigned t;
    apb.data_out      = 16'h1234;
    apb.num_of_errors = 2'd1;
    start_job(2'b10, 2'd0, 16'h00AE, 16'h0022, t);
    exp_res.push_back('{cyc: t + 15, status: 2'b00, errors: 2'd1, data: 16'h1234});
    checks++;
    if (busy !== 1'b1 || job_ready !== 1'b0) begin
      failures++;
      $display("FAIL full_busy busy=%b job_ready=%b required 1 0", busy, job_ready);
    end
    wait_until(t + 14);
    apb.operation_done = 1'b1;
    wait_until(t + 15);
    apb.operation_done = 1'b0;
    wait_until(t + 20);
    checks++;
    if (exp_wr.size() != 0 || exp_res.size() != 0) begin
      failures++;
      $display("FAIL full_drain writes_left=%0d results_left=%0d required 0 0", exp_wr.size(), exp_res.size());
    end
  endtask

  task automatic test_illegal_mode;
    int unsigned t;
    int unsigned p0;
    p0 = psel_cnt;
    start_job(2'b11, 2'd1, 16'h5555, 16'hAAAA, t);
    exp_res.push_back('{cyc: t + 1, status: 2'b10, errors: 2'd0, data: 16'h0});
    wait_until(t + 6);
    checks++;
    if (psel_cnt != p0) begin
      failures++;
      $display("FAIL illegal_psel psel_cycles=%0d required 0", psel_cnt - p0);
    end
    checks++;
    if (exp_res.size() != 0) begin
      failures++;
      $display("FAIL illegal_drain results_left=%0d required 0", exp_res.size());
    end
  endtask

  task automatic test_ignored_done;
    int unsigned t;
    start_job(2'b01, 2'd2, 16'hC0DE, 16'h0101, t);
    wait_until(t + 6);
    apb.data_out       = 16'hBEEF;
    apb.num_of_errors  = 2'd3;
    apb.operation_done = 1'b1;
    wait_until(t + 7);
    apb.operation_done = 1'b0;
    apb.data_out       = 16'h0F0F;
    apb.num_of_errors  = 2'd2;
    exp_res.push_back('{cyc: t + 21, status: 2'b00, errors: 2'd2, data: 16'h0F0F});
    wait_until(t + 20);
    apb.operation_done = 1'b1;
    wait_until(t + 21);
    apb.operation_done = 1'b0;
    wait_until(t + 25);
    checks++;
    if (exp_wr.size() != 0 || exp_res.size() != 0) begin
      failures++;
      $display("FAIL ignored_done_drain writes_left=%0d results_left=%0d required 0 0", exp_wr.size(), exp_res.size());
    end
  endtask

  task automatic test_timeout;
    int unsigned t;
    apb.data_out      = 16'hFFFF;
    apb.num_of_errors = 2'd3;
    start_job(2'b00, 2'd3, 16'h8001, 16'h7FFE, t);
    exp_res.push_back('{cyc: t + 73, status: 2'b01, errors: 2'd0, data: 16'h0});
    wait_until(t + 80);
    checks++;
    if (exp_wr.size() != 0 || exp_res.size() != 0) begin
      failures++;
      $display("FAIL timeout_drain writes_left=%0d results_left=%0d required 0 0", exp_wr.size(), exp_res.size());
    end
    // Completion on the 64th waiting cycle must beat the timeout.
    apb.data_out      = 16'h4321;
    apb.num_of_errors = 2'd1;
    start_job(2'b10, 2'd1, 16'h1111, 16'h2222, t);
    exp_res.push_back('{cyc: t + 73, status: 2'b00, errors: 2'd1, data: 16'h4321});
    wait_until(t + 72);
    apb.operation_done = 1'b1;
    wait_until(t + 73);
    apb.operation_done = 1'b0;
    wait_until(t + 78);
    checks++;
    if (exp_wr.size() != 0 || exp_res.size() != 0) begin
      failures++;
      $display("FAIL timeout_edge_drain writes_left=%0d results_left=%0d required 0 0", exp_wr.size(), exp_res.size());
    end
  endtask

  task automatic test_reset_mid_job;
    int unsigned t;
    start_job(2'b10, 2'd2, 16'h3C3C, 16'h0F00, t);
    wait_until(t + 6);
    checks++;
    if (apb.PSEL !== 1'b1 || apb.PENABLE !== 1'b1 || apb.PADDR !== 20'h4) begin
      failures++;
      $display("FAIL midrst_pre psel=%b penable=%b paddr=%h required 1 1 00004", apb.PSEL, apb.PENABLE, apb.PADDR);
    end
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (apb.PSEL !== 1'b0 || apb.PENABLE !== 1'b0 || res_valid !== 1'b0 || job_ready !== 1'b1) begin
      failures++;
      $display("FAIL midrst_abort psel=%b penable=%b res_valid=%b job_ready=%b required 0 0 0 1",
               apb.PSEL, apb.PENABLE, res_valid, job_ready);
    end
    checks++;
    if (exp_wr.size() != 2) begin
      failures++;
      $display("FAIL midrst_writes pending=%0d required 2", exp_wr.size());
    end
    exp_wr.delete();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    wait_until(cyc + 20);
    apb.data_out      = 16'hA5A5;
    apb.num_of_errors = 2'd0;
    start_job(2'b00, 2'd1, 16'h9999, 16'h0007, t);
    exp_res.push_back('{cyc: t + 10, status: 2'b00, errors: 2'd0, data: 16'hA5A5});
    wait_until(t + 9);
    apb.operation_done = 1'b1;
    wait_until(t + 10);
    apb.operation_done = 1'b0;
    wait_until(t + 15);
    checks++;
    if (exp_wr.size() != 0 || exp_res.size() != 0) begin
      failures++;
      $display("FAIL midrst_drain writes_left=%0d results_left=%0d required 0 0", exp_wr.size(), exp_res.size());
    end
  endtask

  task automatic test_back_to_back;
    int unsigned t;
    acc_q.delete();
    @(posedge clk);
    #1;
    apb.data_out       = 16'h7777;
    apb.num_of_errors  = 2'd3;
    apb.operation_done = 1'b1;
    job_mode  = 2'b10;
    job_width = 2'd2;
    job_data  = 16'h6502;
    job_noise = 16'h0040;
    job_valid = 1'b1;
    t = cyc;
    push_writes(t, 2'b10, 2'd2, 16'h6502, 16'h0040);
    push_writes(t + 11, 2'b10, 2'd2, 16'h6502, 16'h0040);
    exp_res.push_back('{cyc: t + 10, status: 2'b00, errors: 2'd3, data: 16'h7777});
    exp_res.push_back('{cyc: t + 21, status: 2'b00, errors: 2'd3, data: 16'h7777});
    wait_until(t + 12);
    job_valid = 1'b0;
    wait_until(t + 28);
    apb.operation_done = 1'b0;
    checks++;
    if (acc_q.size() != 2) begin
      failures++;
      $display("FAIL b2b_accepts count=%0d required 2", acc_q.size());
    end else if (acc_q[0] != t || acc_q[1] != t + 11) begin
      checks++;
      failures++;
      $display("FAIL b2b_accept_cycles got %0d,%0d required %0d,%0d", acc_q[0], acc_q[1], t, t + 11);
    end
    checks++;
    if (exp_wr.size() != 0 || exp_res.size() != 0) begin
      failures++;
      $display("FAIL b2b_drain writes_left=%0d results_left=%0d required 0 0", exp_wr.size(), exp_res.size());
    end
  endtask

  initial begin
    cyc                = 0;
    checks             = 0;
    failures           = 0;
    psel_cnt           = 0;
    rst                = 1'b0;
    job_valid          = 1'b0;
    job_mode           = '0;
    job_width          = '0;
    job_data           = '0;
    job_noise          = '0;
    apb.operation_done = 1'b0;
    apb.data_out       = '0;
    apb.num_of_errors  = '0;
    test_reset();
    test_full_job();
    test_illegal_mode();
    test_ignored_done();
    test_timeout();
    test_reset_mid_job();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
